// File: rtl/motor_safety_monitor.sv
// Multi-channel motor safety monitor: per-channel ADC rail-stuck, regulation, overcurrent and
// overtemperature detection with masked sticky latching, amplifier disable and priority fault code.

module motor_safety_ch #(
    parameter int ERR_W   = 17,
    parameter int ADC_W   = 16,
    parameter int CNT_W   = 12,
    parameter int STUCK_N = 4
) (
    input  logic             pwmclk,
    input  logic             rst,
    input  logic             clear_disable,
    input  logic             ctrl_active,
    input  logic             err_valid,
    input  logic [ERR_W-1:0] err_in,
    input  logic [15:0]      err_thresh,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_in,
    input  logic             hb_fault_n,
    input  logic             hb_otw_n,
    input  logic [3:0]       fault_mask,
    output logic [3:0]       fault_latched,
    output logic [3:0]       fault_code,
    output logic             amp_disable
);
    localparam int              CMP_W      = (ERR_W > 16) ? ERR_W : 16;
    localparam logic [CNT_W-1:0] CNT_TOP   = '1;
    localparam logic [3:0]      STUCK_MAX  = 4'(STUCK_N);
    localparam logic [ERR_W-1:0] ERR_MIN   = {1'b1, {(ERR_W-1){1'b0}}};
    localparam logic [ERR_W-1:0] ERR_MAXP  = {1'b0, {(ERR_W-1){1'b1}}};
    localparam logic [ERR_W-1:0] ERR_ONE   = {{(ERR_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic otemp;
        logic ocur;
        logic reg_f;
        logic adc;
    } fault_t;

    logic [CNT_W-1:0] reg_cnt;
    logic [3:0]       stuck_cnt;
    logic [ERR_W-1:0] err_abs;
    logic             err_bad;
    logic             adc_rail;
    fault_t           raw;
    logic [3:0]       code_nxt;

    // Most-negative input has no positive twin; clamp it to the largest magnitude.
    always_comb begin
        err_abs = err_in[ERR_W-1] ? (~err_in + ERR_ONE) : err_in;
        if (err_in == ERR_MIN)
            err_abs = ERR_MAXP;
    end

    assign err_bad  = CMP_W'(err_abs) > CMP_W'(err_thresh);
    assign adc_rail = (adc_in == '0) || (adc_in == '1);

    always_ff @(posedge pwmclk) begin
        if (rst || clear_disable || !ctrl_active)
            reg_cnt <= CNT_TOP;
        else if (err_valid) begin
            if (err_bad)
                reg_cnt <= (reg_cnt == '0) ? reg_cnt : reg_cnt - 1'b1;
            else
                reg_cnt <= (reg_cnt == CNT_TOP) ? reg_cnt : reg_cnt + 1'b1;
        end
    end

    always_ff @(posedge pwmclk) begin
        if (rst || clear_disable)
            stuck_cnt <= '0;
        else if (adc_valid) begin
            if (adc_rail)
                stuck_cnt <= (stuck_cnt == STUCK_MAX) ? stuck_cnt : stuck_cnt + 1'b1;
            else
                stuck_cnt <= '0;
        end
    end

    // Counter-based faults look at last cycle's registered state, so they latch one edge late.
    always_comb begin
        raw.adc   = (stuck_cnt == STUCK_MAX);
        raw.reg_f = (reg_cnt == '0) && ctrl_active;
        raw.ocur  = ~hb_fault_n & hb_otw_n;
        raw.otemp = ~hb_fault_n & ~hb_otw_n;
    end

    always_ff @(posedge pwmclk) begin
        if (rst || clear_disable)
            fault_latched <= '0;
        else
            fault_latched <= fault_latched | (raw & ~fault_mask);
    end

    always_comb begin
        code_nxt = 4'd0;
        if (fault_latched[3]) code_nxt = 4'd4;
        if (fault_latched[2]) code_nxt = 4'd3;
        if (fault_latched[1]) code_nxt = 4'd2;
        if (fault_latched[0]) code_nxt = 4'd1;
    end

    always_ff @(posedge pwmclk) begin
        if (rst) begin
            amp_disable <= 1'b0;
            fault_code  <= '0;
        end else begin
            amp_disable <= |fault_latched;
            fault_code  <= code_nxt;
        end
    end
endmodule

module motor_safety_monitor #(
    parameter int NUM_CH  = 4,
    parameter int ERR_W   = 17,
    parameter int ADC_W   = 16,
    parameter int CNT_W   = 12,
    parameter int STUCK_N = 4
) (
    input  logic                    pwmclk,
    input  logic                    rst,
    input  logic                    clear_disable,
    input  logic [NUM_CH-1:0]       ctrl_active,
    input  logic [NUM_CH-1:0]       err_valid,
    input  logic [NUM_CH*ERR_W-1:0] err_in,
    input  logic [NUM_CH*16-1:0]    err_thresh,
    input  logic [NUM_CH-1:0]       adc_valid,
    input  logic [NUM_CH*ADC_W-1:0] adc_in,
    input  logic [NUM_CH-1:0]       hb_fault_n,
    input  logic [NUM_CH-1:0]       hb_otw_n,
    input  logic [NUM_CH*4-1:0]     fault_mask,
    output logic [NUM_CH*4-1:0]     fault_latched,
    output logic [NUM_CH*4-1:0]     fault_code,
    output logic [NUM_CH-1:0]       amp_disable,
    output logic                    any_fault
);
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        motor_safety_ch #(
            .ERR_W  (ERR_W),
            .ADC_W  (ADC_W),
            .CNT_W  (CNT_W),
            .STUCK_N(STUCK_N)
        ) u_ch (
            .pwmclk       (pwmclk),
            .rst          (rst),
            .clear_disable(clear_disable),
            .ctrl_active  (ctrl_active[c]),
            .err_valid    (err_valid[c]),
            .err_in       (err_in[c*ERR_W +: ERR_W]),
            .err_thresh   (err_thresh[c*16 +: 16]),
            .adc_valid    (adc_valid[c]),
            .adc_in       (adc_in[c*ADC_W +: ADC_W]),
            .hb_fault_n   (hb_fault_n[c]),
            .hb_otw_n     (hb_otw_n[c]),
            .fault_mask   (fault_mask[c*4 +: 4]),
            .fault_latched(fault_latched[c*4 +: 4]),
            .fault_code   (fault_code[c*4 +: 4]),
            .amp_disable  (amp_disable[c])
        );
    end

    assign any_fault = |amp_disable;
endmodule

// File: tb/tb_motor_safety_monitor.sv
// Directed bench for motor_safety_monitor with a 4-bit regulation counter so faults arrive quickly.

module tb_motor_safety_monitor;
    localparam int NUM_CH = 4, ERR_W = 17, ADC_W = 16, CNT_W = 4, STUCK_N = 4;

    logic                    pwmclk = 1'b0;
    logic                    rst = 1'b1;
    logic                    clear_disable = 1'b0;
    logic [NUM_CH-1:0]       ctrl_active = '0;
    logic [NUM_CH-1:0]       err_valid = '0;
    logic [NUM_CH*ERR_W-1:0] err_in = '0;
    logic [NUM_CH*16-1:0]    err_thresh = '0;
    logic [NUM_CH-1:0]       adc_valid = '0;
    logic [NUM_CH*ADC_W-1:0] adc_in = '0;
    logic [NUM_CH-1:0]       hb_fault_n = '1;
    logic [NUM_CH-1:0]       hb_otw_n = '1;
    logic [NUM_CH*4-1:0]     fault_mask = '0;
    logic [NUM_CH*4-1:0]     fault_latched;
    logic [NUM_CH*4-1:0]     fault_code;
    logic [NUM_CH-1:0]       amp_disable;
    logic                    any_fault;

    int n_chk = 0;
    int n_err = 0;

    motor_safety_monitor #(
        .NUM_CH(NUM_CH), .ERR_W(ERR_W), .ADC_W(ADC_W), .CNT_W(CNT_W), .STUCK_N(STUCK_N)
    ) dut (
        .pwmclk(pwmclk), .rst(rst), .clear_disable(clear_disable), .ctrl_active(ctrl_active),
        .err_valid(err_valid), .err_in(err_in), .err_thresh(err_thresh), .adc_valid(adc_valid),
        .adc_in(adc_in), .hb_fault_n(hb_fault_n), .hb_otw_n(hb_otw_n), .fault_mask(fault_mask),
        .fault_latched(fault_latched), .fault_code(fault_code), .amp_disable(amp_disable),
        .any_fault(any_fault)
    );

    always #5 pwmclk = ~pwmclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pwmclk);
        #1;
    endtask

    task automatic err_strobe(input int ch, input logic [ERR_W-1:0] v);
        err_in[ch*ERR_W +: ERR_W] = v;
        err_valid[ch] = 1'b1;
        step();
        err_valid[ch] = 1'b0;
    endtask

    task automatic adc_strobe(input int ch, input logic [ADC_W-1:0] v);
        adc_in[ch*ADC_W +: ADC_W] = v;
        adc_valid[ch] = 1'b1;
        step();
        adc_valid[ch] = 1'b0;
    endtask

    task automatic clear_pulse();
        clear_disable = 1'b1;
        step();
        clear_disable = 1'b0;
    endtask

    initial begin
        adc_in = {NUM_CH{16'h1234}};
        step(); step();
        check("rst_latched", 32'(fault_latched), 32'h0);
        check("rst_code",    32'(fault_code),    32'h0);
        check("rst_amp",     32'(amp_disable),   32'h0);
        check("rst_any",     32'(any_fault),     32'h0);
        rst = 1'b0;

        // 1: ch0 regulation countdown 15 -> 0
        ctrl_active = 4'b0001;
        err_thresh[0 +: 16] = 16'h0200;
        repeat (14) err_strobe(0, 17'h00300);
        check("t1_cnt1", 32'(fault_latched), 32'h0);
        err_strobe(0, 17'h00300);
        check("t1_cnt0_edge", 32'(fault_latched), 32'h0);
        step();
        check("t1_latch", 32'(fault_latched), 32'h0002);
        check("t1_amp_lag", 32'(amp_disable), 32'h0);
        step();
        check("t1_amp",  32'(amp_disable), 32'h1);
        check("t1_code", 32'(fault_code),  32'h0002);
        check("t1_any",  32'(any_fault),   32'h1);
        clear_pulse();
        check("t1_clr_latch", 32'(fault_latched), 32'h0);
        step();
        check("t1_clr_amp", 32'(amp_disable), 32'h0);

        // 2: ch1 magnitude handling
        ctrl_active = 4'b0010;
        err_thresh[16 +: 16] = 16'h8000;
        repeat (15) err_strobe(1, 17'h10000);
        step();
        check("t2_mostneg_bad", 32'(fault_latched), 32'h0020);
        clear_pulse();
        err_thresh[16 +: 16] = 16'h0200;
        repeat (10) begin
            err_strobe(1, 17'h10000);
            err_strobe(1, 17'h00100);
        end
        step();
        check("t2_alternate", 32'(fault_latched), 32'h0);
        err_thresh[16 +: 16] = 16'hFFFF;
        repeat (16) err_strobe(1, 17'h10000);
        step();
        check("t2_sat_eq_thresh", 32'(fault_latched), 32'h0);
        err_thresh[16 +: 16] = 16'h02FF;
        repeat (15) err_strobe(1, 17'h1FD00);
        step();
        check("t2_neg_bad", 32'(fault_latched), 32'h0020);
        err_thresh[16 +: 16] = 16'h0300;
        clear_pulse();
        repeat (20) err_strobe(1, 17'h00300);
        step();
        check("t2_eq_not_bad", 32'(fault_latched), 32'h0);
        ctrl_active = 4'b0000;
        clear_pulse();

        // 3: ch2 ADC stuck debounce
        repeat (3) adc_strobe(2, 16'hFFFF);
        adc_strobe(2, 16'h1234);
        repeat (3) adc_strobe(2, 16'h0000);
        step();
        check("t3_three", 32'(fault_latched), 32'h0);
        adc_strobe(2, 16'h0000);
        check("t3_fourth_edge", 32'(fault_latched), 32'h0);
        step();
        check("t3_latch", 32'(fault_latched), 32'h0100);
        step();
        check("t3_code", 32'(fault_code),  32'h0100);
        check("t3_amp",  32'(amp_disable), 32'h4);
        clear_pulse();
        step();

        // 4: H-bridge faults and priority
        hb_fault_n = 4'b1110;
        step();
        check("t4_ocur_latch", 32'(fault_latched), 32'h0004);
        step();
        check("t4_ocur_code", 32'(fault_code), 32'h0003);
        hb_fault_n = 4'b1111;
        clear_pulse();
        hb_fault_n = 4'b0111;
        hb_otw_n   = 4'b0111;
        step();
        check("t4_otemp_latch", 32'(fault_latched), 32'h8000);
        step();
        check("t4_otemp_code", 32'(fault_code), 32'h4000);
        repeat (4) adc_strobe(3, 16'h0000);
        step();
        check("t4_both_latch", 32'(fault_latched), 32'h9000);
        step();
        check("t4_prio_code", 32'(fault_code), 32'h1000);
        clear_pulse();
        check("t4_clear_wins", 32'(fault_latched), 32'h0);
        step();
        check("t4_relatch", 32'(fault_latched), 32'h8000);
        check("t4_code_gap", 32'(fault_code),  32'h0);
        check("t4_amp_gap",  32'(amp_disable), 32'h0);
        step();
        check("t4_code_back", 32'(fault_code), 32'h4000);
        hb_fault_n = 4'b1111;
        hb_otw_n   = 4'b1111;
        clear_pulse();
        step();

        // 5: masking, ctrl_active drop, mid-sequence reset
        ctrl_active = 4'b0001;
        fault_mask  = 16'h0002;
        repeat (15) err_strobe(0, 17'h00300);
        step(); step();
        check("t5_masked", 32'(fault_latched), 32'h0);
        fault_mask = 16'h0000;
        step();
        check("t5_unmask", 32'(fault_latched), 32'h0002);
        fault_mask = 16'h0002;
        step();
        check("t5_mask_after", 32'(fault_latched), 32'h0002);
        fault_mask = 16'h0000;
        clear_pulse();
        repeat (14) err_strobe(0, 17'h00300);
        ctrl_active = 4'b0000;
        step();
        ctrl_active = 4'b0001;
        repeat (14) err_strobe(0, 17'h00300);
        step();
        check("t5_inactive_top", 32'(fault_latched), 32'h0);
        err_strobe(0, 17'h00300);
        step();
        check("t5_inactive_full", 32'(fault_latched), 32'h0002);
        clear_pulse();
        repeat (10) err_strobe(0, 17'h00300);
        hb_fault_n = 4'b0111;
        step(); step();
        check("t5_pre_rst", 32'(fault_latched), 32'h4000);
        rst = 1'b1;
        step();
        check("t5_rst_latch", 32'(fault_latched), 32'h0);
        check("t5_rst_code",  32'(fault_code),    32'h0);
        check("t5_rst_amp",   32'(amp_disable),   32'h0);
        check("t5_rst_any",   32'(any_fault),     32'h0);
        rst = 1'b0;
        hb_fault_n = 4'b1111;
        repeat (14) err_strobe(0, 17'h00300);
        step();
        check("t5_rst_top", 32'(fault_latched), 32'h0);
        err_strobe(0, 17'h00300);
        step();
        check("t5_rst_full", 32'(fault_latched), 32'h0002);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
